// File: rtl/alu_arbiter_if.sv
// Requester-side bundle for alu_arbiter: two request channels in,
// a per-requester response pulse out.
interface alu_arbiter_if #(
    parameter int DATA_W = 8
);
    logic [1:0]          req_valid;
    logic [3:0]          req_op;
    logic [2*DATA_W-1:0] req_a;
    logic [2*DATA_W-1:0] req_b;
    logic [1:0]          req_ready;
    logic [1:0]          rsp_valid;
    logic                rsp_err;
    logic [2*DATA_W-1:0] rsp_result;

    modport master (
        output req_valid, req_op, req_a, req_b,
        input  req_ready, rsp_valid, rsp_err, rsp_result
    );

    modport slave (
        input  req_valid, req_op, req_a, req_b,
        output req_ready, rsp_valid, rsp_err, rsp_result
    );
endinterface

// File: rtl/alu_arbiter.sv
// Two-requester round-robin front end for a shared multi-cycle ALU,
// with illegal-opcode rejection and a completion timeout.
module alu_arbiter #(
    parameter int DATA_W  = 8,
    parameter int TIMEOUT = 31
) (
    input  logic                clk,
    input  logic                rst_n,
    alu_arbiter_if.slave        bus,
    output logic                alu_start,
    output logic [1:0]          alu_opcode,
    output logic [DATA_W-1:0]   alu_a,
    output logic [DATA_W-1:0]   alu_b,
    input  logic                alu_done,
    input  logic [2*DATA_W-1:0] alu_result
);
    localparam int TW = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        RESP
    } state_t;

    state_t              state;
    logic                last_grant;
    logic                grant;
    logic [1:0]          cap_op;
    logic [DATA_W-1:0]   cap_a;
    logic [DATA_W-1:0]   cap_b;
    logic [TW-1:0]       timer;
    logic [1:0]          rsp_valid_q;
    logic                rsp_err_q;
    logic [2*DATA_W-1:0] rsp_result_q;

    logic                sel;
    logic                accept;
    logic                drive;
    logic [1:0]          sel_op;
    logic [DATA_W-1:0]   sel_a;
    logic [DATA_W-1:0]   sel_b;
    logic [1:0]          grant_oh;
    logic [1:0]          sel_oh;

    // With both requesters pending the one not served last wins.
    always_comb begin
        sel    = (&bus.req_valid) ? ~last_grant : bus.req_valid[1];
        accept = (state == IDLE) && (|bus.req_valid);
        sel_oh = sel ? 2'b10 : 2'b01;
        sel_op = sel ? bus.req_op[3:2] : bus.req_op[1:0];
        sel_a  = sel ? bus.req_a[2*DATA_W-1:DATA_W] : bus.req_a[DATA_W-1:0];
        sel_b  = sel ? bus.req_b[2*DATA_W-1:DATA_W] : bus.req_b[DATA_W-1:0];
        grant_oh = grant ? 2'b10 : 2'b01;
        drive  = (state == ISSUE) || (state == WAIT);
    end

    assign bus.req_ready  = accept ? sel_oh : 2'b00;
    assign bus.rsp_valid  = rsp_valid_q;
    assign bus.rsp_err    = rsp_err_q;
    assign bus.rsp_result = rsp_result_q;

    assign alu_opcode = drive ? cap_op : 2'b00;
    assign alu_a      = drive ? cap_a : '0;
    assign alu_b      = drive ? cap_b : '0;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= IDLE;
            last_grant   <= 1'b1;
            grant        <= 1'b0;
            cap_op       <= 2'b00;
            cap_a        <= '0;
            cap_b        <= '0;
            timer        <= '0;
            alu_start    <= 1'b0;
            rsp_valid_q  <= 2'b00;
            rsp_err_q    <= 1'b0;
            rsp_result_q <= '0;
        end else begin
            alu_start    <= 1'b0;
            rsp_valid_q  <= 2'b00;
            rsp_err_q    <= 1'b0;
            rsp_result_q <= '0;
            unique case (state)
                IDLE: begin
                    if (accept) begin
                        grant  <= sel;
                        cap_op <= sel_op;
                        cap_a  <= sel_a;
                        cap_b  <= sel_b;
                        if (sel_op == 2'b11) begin
                            state       <= RESP;
                            rsp_valid_q <= sel_oh;
                            rsp_err_q   <= 1'b1;
                        end else begin
                            state     <= ISSUE;
                            alu_start <= 1'b1;
                        end
                    end
                end
                ISSUE: begin
                    timer <= '0;
                    state <= WAIT;
                end
                WAIT: begin
                    // Completion takes priority over an expiring timer.
                    if (alu_done) begin
                        state        <= RESP;
                        rsp_valid_q  <= grant_oh;
                        rsp_result_q <= alu_result;
                    end else if (timer == TW'(TIMEOUT)) begin
                        state       <= RESP;
                        rsp_valid_q <= grant_oh;
                        rsp_err_q   <= 1'b1;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                RESP: begin
                    last_grant <= grant;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_alu_arbiter.sv
// Scoreboard bench for alu_arbiter: randomized requests, a behavioural
// fake ALU, and a monitor that checks every response pulse.
module tb_alu_arbiter;
    localparam int DW = 8;
    localparam int TO = 31;

    typedef struct {
        logic [1:0]  v;
        logic        err;
        logic [15:0] res;
        int          cyc;
    } exp_t;

    logic          clk;
    logic          rst_n;
    logic          alu_start;
    logic [1:0]    alu_opcode;
    logic [DW-1:0] alu_a;
    logic [DW-1:0] alu_b;
    logic          alu_done;
    logic [15:0]   alu_result;

    alu_arbiter_if #(.DATA_W(DW)) bus ();

    alu_arbiter #(.DATA_W(DW), .TIMEOUT(TO)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .bus        (bus),
        .alu_start  (alu_start),
        .alu_opcode (alu_opcode),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_done   (alu_done),
        .alu_result (alu_result)
    );

    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;
    exp_t sb[$];
    exp_t mon_e;

    int         alu_delay = 0;
    bit         pend = 0;
    int         cnt = 0;
    logic [1:0] p_op;
    logic [7:0] p_a;
    logic [7:0] p_b;
    int         starts = 0;
    int         exp_starts = 0;
    bit         hold_bad = 0;
    bit         stray = 0;
    bit         alu_abort = 0;
    bit         lg = 1;

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at cycle %0d", nm, act, exp, cyc);
        end
    endtask

    function automatic logic [15:0] alu_fn(input logic [1:0] op, input logic [7:0] a,
                                           input logic [7:0] b);
        case (op)
            2'b00:   return 16'(a) + 16'(b);
            2'b01:   return 16'(a) * 16'(b);
            2'b10:   return (b == 8'd0) ? 16'hffff : 16'(a / b);
            default: return 16'h0000;
        endcase
    endfunction

    // Fake ALU controller: answers each start after alu_delay WAIT cycles
    // (negative = never), and watches the operand bus while busy.
    initial begin
        alu_done   = 0;
        alu_result = 0;
        forever begin
            @(negedge clk);
            if (alu_abort) begin
                pend      = 0;
                alu_abort = 0;
            end
            if (bus.rsp_valid != 2'b00) pend = 0;
            if (alu_start) begin
                starts++;
                pend = 1;
                cnt  = alu_delay;
                p_op = alu_opcode;
                p_a  = alu_a;
                p_b  = alu_b;
            end else if (pend && (alu_opcode != p_op || alu_a != p_a || alu_b != p_b)) begin
                hold_bad = 1;
            end
            @(posedge clk);
            #1;
            alu_done = 0;
            if (pend && cnt == 0) begin
                alu_done   = 1;
                alu_result = alu_fn(p_op, p_a, p_b);
                pend       = 0;
            end else if (pend && cnt > 0) begin
                cnt--;
            end
            if (stray) begin
                alu_done   = 1;
                alu_result = 16'($urandom);
                stray      = 0;
            end
        end
    end

    // Response monitor.
    initial begin
        forever begin
            @(negedge clk);
            if (bus.rsp_valid != 2'b00) begin
                if (sb.size() == 0) begin
                    chk("rsp_unexpected", bus.rsp_valid, 2'b00);
                end else begin
                    mon_e = sb.pop_front();
                    chk("rsp_valid", bus.rsp_valid, mon_e.v);
                    chk("rsp_err", bus.rsp_err, mon_e.err);
                    chk("rsp_result", bus.rsp_result, mon_e.res);
                    chk("rsp_cycle", cyc, mon_e.cyc);
                end
            end
        end
    end

    // Called at posedge+1 with the DUT idle; returns at posedge+1 of the
    // cycle after the response.
    task automatic run_txn(input logic [1:0] vm, input logic [3:0] op,
                           input logic [15:0] a, input logic [15:0] b, input int dly);
        int         g;
        int         n;
        int         t;
        logic [1:0] og;
        logic [7:0] ag;
        logic [7:0] bg;
        logic [1:0] rdy;
        exp_t       e;
        bit         busy_bad;
        bit         done;
        bus.req_valid = vm;
        bus.req_op    = op;
        bus.req_a     = a;
        bus.req_b     = b;
        alu_delay     = dly;
        hold_bad      = 0;
        g = (vm == 2'b11) ? int'(!lg) : int'(vm[1]);
        @(negedge clk);
        rdy = bus.req_ready;
        chk("req_ready", rdy, (g == 1) ? 2'b10 : 2'b01);
        if (rdy == 2'b00) begin
            bus.req_valid = 2'b00;
            @(posedge clk);
            #1;
            return;
        end
        t  = cyc;
        og = op[2*g +: 2];
        ag = a[8*g +: 8];
        bg = b[8*g +: 8];
        e.v = (g == 1) ? 2'b10 : 2'b01;
        if (og == 2'b11) begin
            e.err = 1;
            e.res = 0;
            e.cyc = t + 1;
        end else begin
            exp_starts++;
            if (dly < 0 || dly > TO) begin
                e.err = 1;
                e.res = 0;
                e.cyc = t + 3 + TO;
            end else begin
                e.err = 0;
                e.res = alu_fn(og, ag, bg);
                e.cyc = t + 3 + dly;
            end
        end
        sb.push_back(e);
        lg = g[0];
        @(posedge clk);
        #1;
        bus.req_a  = 16'($urandom);
        bus.req_b  = 16'($urandom);
        bus.req_op = 4'($urandom);
        @(negedge clk);
        chk("alu_start", alu_start, og != 2'b11);
        busy_bad = 0;
        done     = 0;
        n        = 0;
        while (!done) begin
            if (bus.req_ready != 2'b00) busy_bad = 1;
            @(posedge clk);
            #1;
            n++;
            if (sb.size() == 0 || n > TO + 20) done = 1;
            else @(negedge clk);
        end
        if (sb.size() != 0) begin
            chk("rsp_timeout", sb.size(), 0);
            sb.delete();
        end
        chk("ready_busy", busy_bad, 0);
        chk("alu_hold", hold_bad, 0);
        chk("alu_starts", starts, exp_starts);
    endtask

    task automatic idle_gap(input int n, input bit stray_done);
        bus.req_valid = 2'b00;
        if (stray_done) stray = 1;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            chk("idle_alu", {alu_start, alu_opcode, alu_a, alu_b}, 0);
            chk("idle_ready", bus.req_ready, 2'b00);
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk_all_zero(input string nm);
        chk({nm, "_ready"}, bus.req_ready, 2'b00);
        chk({nm, "_rsp_valid"}, bus.rsp_valid, 2'b00);
        chk({nm, "_rsp_err"}, bus.rsp_err, 1'b0);
        chk({nm, "_rsp_result"}, bus.rsp_result, 16'h0);
        chk({nm, "_alu"}, {alu_start, alu_opcode, alu_a, alu_b}, 0);
    endtask

    function automatic int rand_delay();
        int r;
        r = int'($urandom_range(0, 9));
        if (r == 0) return -1;
        if (r == 1) return TO;
        return int'($urandom_range(0, 6));
    endfunction

    function automatic logic [3:0] legal_ops();
        logic [3:0] o;
        o[1:0] = 2'($urandom_range(0, 2));
        o[3:2] = 2'($urandom_range(0, 2));
        return o;
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n         = 0;
        bus.req_valid = 2'b00;
        bus.req_op    = 4'h0;
        bus.req_a     = 16'h0;
        bus.req_b     = 16'h0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_all_zero("reset");
        @(posedge clk);
        #1;
        rst_n = 1;

        run_txn(2'b01, 4'b0000, 16'h0005, 16'h0003, 2);

        for (int i = 0; i < 6; i++)
            run_txn(2'b11, legal_ops(), 16'($urandom), 16'($urandom),
                    int'($urandom_range(0, 4)));

        idle_gap(3, 1);

        run_txn(2'b10, 4'b1100, 16'($urandom), 16'($urandom), 0);
        run_txn(2'b01, 4'b0001, 16'h0c0d, 16'h0b0e, -1);
        run_txn(2'b01, 4'b0001, 16'h0c0d, 16'h0b0e, TO);
        run_txn(2'b10, 4'b0100, 16'h2211, 16'h0733, TO - 1);

        // Abandon an operation mid-WAIT with a one-cycle reset.
        bus.req_valid = 2'b01;
        bus.req_op    = 4'b0001;
        bus.req_a     = 16'h0042;
        bus.req_b     = 16'h0017;
        alu_delay     = -1;
        @(negedge clk);
        chk("rst_accept", bus.req_ready, 2'b01);
        exp_starts++;
        @(posedge clk);
        #1;
        bus.req_valid = 2'b00;
        repeat (4) @(posedge clk);
        #1;
        rst_n     = 0;
        alu_abort = 1;
        @(posedge clk);
        #1;
        rst_n = 1;
        @(negedge clk);
        chk_all_zero("midrst");
        lg = 1;
        @(posedge clk);
        #1;
        idle_gap(4, 1);
        run_txn(2'b11, 4'b0000, 16'h1020, 16'h0304, 1);

        for (int i = 0; i < 40; i++) begin
            run_txn(2'($urandom_range(1, 3)), 4'($urandom), 16'($urandom),
                    16'($urandom), rand_delay());
            if ($urandom_range(0, 4) == 0) idle_gap(int'($urandom_range(1, 3)), 1);
        end

        idle_gap(2, 0);
        chk("sb_drained", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 Parameter DATA_W, default 8, operand width; results are 2*DATA_W bits.
REQ-002 Parameter TIMEOUT, default 31, max WAIT cycles before error; timer width is clog2(TIMEOUT+1).
REQ-003 clk  in  1  single clock; all state changes on rising edge.
REQ-004 rst_n  in  1  synchronous, active-low reset.
REQ-005 req_valid  in  2  bit n = requester n has a pending operation.
REQ-006 req_op  in  4  requester n opcode at [2n+1:2n]; 00 ADD/SUB, 01 MUL, 10 DIV, 11 illegal.
REQ-007 req_a  in  2*DATA_W  requester n operand A at [n*DATA_W +: DATA_W].
REQ-008 req_b  in  2*DATA_W  requester n operand B, same packing.
REQ-009 req_ready  out  2  bit n = request n accepted this cycle (valid&ready).
REQ-010 rsp_valid  out  2  bit n = one-cycle response pulse to requester n.
REQ-011 rsp_err  out  1  response is error (illegal opcode or timeout); qualified by rsp_valid.
REQ-012 rsp_result  out  2*DATA_W  result; qualified by rsp_valid; zero on error.
REQ-013 alu_start  out  1  one-cycle start pulse to ALU controller.
REQ-014 alu_opcode  out  2  opcode to ALU controller.
REQ-015 alu_a, alu_b  out  DATA_W each  operands to ALU datapath.
REQ-016 alu_done  in  1  ALU controller completion pulse.
REQ-017 alu_result  in  2*DATA_W  ALU result, valid with alu_done.

Function
REQ-018 FSM states SHALL be IDLE, ISSUE, WAIT, RESP.
REQ-019 IDLE: if any req_valid bit set, arbiter SHALL grant exactly one requester and assert only its req_ready bit in that cycle; req_ready is 0 in all other states.
REQ-020 Arbitration SHALL be round-robin: with both valid, grant the requester not equal to last_grant; with one valid, grant it.
REQ-021 On accept, op/a/b and grant index SHALL be captured into registers; next state RESP with err=1 if op==11, else ISSUE.
REQ-022 ISSUE: alu_start=1 for exactly one cycle; timer cleared to 0; next state WAIT.
REQ-023 alu_opcode/alu_a/alu_b SHALL be driven from captured registers and held stable from ISSUE through WAIT; 0 in IDLE.
REQ-024 WAIT: timer increments each cycle; on alu_done capture alu_result, err=0, go RESP.
REQ-025 WAIT: if timer==TIMEOUT with no alu_done, err=1, result=0, go RESP; alu_done wins when simultaneous.
REQ-026 RESP: rsp_valid[grant]=1 for one cycle with rsp_result/rsp_err; last_grant<=grant; next state IDLE; no response backpressure.
REQ-027 alu_done outside WAIT SHALL be ignored.
REQ-028 Latency: accept at cycle T -> alu_start at T+1; response one cycle after alu_done; illegal opcode response at T+1.
REQ-029 Next alu_start SHALL be at least 3 cycles after alu_done (RESP, IDLE, ISSUE), keeping the ALU controller's DONE->IDLE return satisfied.
REQ-030 No output SHALL depend combinationally on alu_done or alu_result; req_ready depends only on state, req_valid, last_grant.

Reset
REQ-031 While rst_n=0 at a clock edge: state IDLE, last_grant=1 (requester 0 wins first tie), timer 0, captured registers 0, all outputs 0.
REQ-032 Reset in ISSUE/WAIT/RESP SHALL abandon the operation with no response; a later stray alu_done is ignored.

Verification
REQ-033 Single: req0 op=00 a=5 b=3 -> ready0 at T, alu_start at T+1, alu_done with result 8 -> rsp_valid=01, result 8, err 0 next cycle.
REQ-034 Contention: both valid continuously after reset -> grants alternate 0,1,0,1; each rsp_valid bit matches its grant.
REQ-035 Illegal: req1 op=11 -> ready1 at T, no alu_start, rsp_valid=10, err=1, result 0 at T+1.
REQ-036 Timeout: op=01, alu_done never -> rsp err=1 after TIMEOUT+1 WAIT cycles; alu_done on final WAIT cycle instead -> err=0, result from ALU.
REQ-037 Reset mid-WAIT: rst_n low one cycle -> all outputs 0, no rsp_valid; following alu_done ignored; new request serviced normally.
REQ-038 Operand hold: change req_a/req_b after accept -> alu_a/alu_b unchanged until response.
